// File: rtl/chess_turn_controller.sv
// rtl/chess_turn_controller.sv - chess clock turn, pause and game-over controller
module chess_turn_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int MOVE_W      = 8,
  parameter int INC_EN      = 1
) (
  input  logic              OutClock,
  input  logic              reset,
  input  logic              StartPause,
  input  logic              WhiteMove,
  input  logic              BlackMove,
  input  logic              WhiteTimeout,
  input  logic              BlackTimeout,
  output logic              WhiteFlag,
  output logic              BlackFlag,
  output logic              TimerReset,
  output logic              IncWhite,
  output logic              IncBlack,
  output logic              GameOver,
  output logic [1:0]        Winner,
  output logic [MOVE_W-1:0] MoveCount,
  output logic [2:0]        State
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WHITE_RUN = 3'd1,
    S_BLACK_RUN = 3'd2,
    S_PAUSED    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0]        WIN_NONE  = 2'b00;
  localparam logic [1:0]        WIN_WHITE = 2'b01;
  localparam logic [1:0]        WIN_BLACK = 2'b10;
  localparam logic [MOVE_W-1:0] CNT_MAX   = '1;
  localparam logic              INC_ON    = (INC_EN != 0);

  // Button lanes: bit 0 StartPause, bit 1 WhiteMove, bit 2 BlackMove.
  logic [2:0]        r_sync [SYNC_STAGES];
  logic [2:0]        r_prev;
  logic [2:0]        r_evt;
  logic [2:0]        w_btn;
  logic [2:0]        w_sync_last;
  logic              w_ev_sp;
  logic              w_ev_wm;
  logic              w_ev_bm;
  logic [MOVE_W-1:0] w_count_next;

  state_t            r_state;
  logic              r_saved_black;
  logic              r_white_flag;
  logic              r_black_flag;
  logic              r_game_over;
  logic              r_timer_reset;
  logic              r_inc_white;
  logic              r_inc_black;
  logic [1:0]        r_winner;
  logic [MOVE_W-1:0] r_count;

  assign w_btn       = {BlackMove, WhiteMove, StartPause};
  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign w_ev_sp     = r_evt[0];
  assign w_ev_wm     = r_evt[1];
  assign w_ev_bm     = r_evt[2];

  // Saturating half-move count; it never wraps back to zero.
  assign w_count_next = (r_count == CNT_MAX) ? r_count : r_count + MOVE_W'(1);

  // Synchronize the raw buttons and register a one-cycle rising-edge event.
  // Everything resets high so a button held through reset release is
  // treated as already pressed and produces no event.
  always_ff @(posedge OutClock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '1;
      end
      r_prev <= '1;
      r_evt  <= '0;
    end else begin
      r_sync[0] <= w_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sync_last;
      r_evt  <= w_sync_last & ~r_prev;
    end
  end

  // Turn FSM with all outputs registered alongside the state they belong to.
  always_ff @(posedge OutClock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_saved_black <= 1'b0;
      r_white_flag  <= 1'b0;
      r_black_flag  <= 1'b0;
      r_game_over   <= 1'b0;
      r_timer_reset <= 1'b0;
      r_inc_white   <= 1'b0;
      r_inc_black   <= 1'b0;
      r_winner      <= WIN_NONE;
      r_count       <= '0;
    end else begin
      r_timer_reset <= 1'b0;
      r_inc_white   <= 1'b0;
      r_inc_black   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ev_sp) begin
            r_state      <= S_WHITE_RUN;
            r_white_flag <= 1'b1;
          end
        end
        S_WHITE_RUN: begin
          // A flag fall outranks a move landing in the same cycle.
          if (WhiteTimeout) begin
            r_state      <= S_GAME_OVER;
            r_white_flag <= 1'b0;
            r_game_over  <= 1'b1;
            r_winner     <= WIN_BLACK;
          end else if (w_ev_wm) begin
            r_state      <= S_BLACK_RUN;
            r_white_flag <= 1'b0;
            r_black_flag <= 1'b1;
            r_count      <= w_count_next;
            r_inc_white  <= INC_ON;
          end else if (w_ev_sp) begin
            r_state       <= S_PAUSED;
            r_white_flag  <= 1'b0;
            r_saved_black <= 1'b0;
          end
        end
        S_BLACK_RUN: begin
          if (BlackTimeout) begin
            r_state      <= S_GAME_OVER;
            r_black_flag <= 1'b0;
            r_game_over  <= 1'b1;
            r_winner     <= WIN_WHITE;
          end else if (w_ev_bm) begin
            r_state      <= S_WHITE_RUN;
            r_black_flag <= 1'b0;
            r_white_flag <= 1'b1;
            r_count      <= w_count_next;
            r_inc_black  <= INC_ON;
          end else if (w_ev_sp) begin
            r_state       <= S_PAUSED;
            r_black_flag  <= 1'b0;
            r_saved_black <= 1'b1;
          end
        end
        S_PAUSED: begin
          if (w_ev_sp) begin
            if (r_saved_black) begin
              r_state      <= S_BLACK_RUN;
              r_black_flag <= 1'b1;
            end else begin
              r_state      <= S_WHITE_RUN;
              r_white_flag <= 1'b1;
            end
          end
        end
        S_GAME_OVER: begin
          if (w_ev_sp) begin
            r_state       <= S_IDLE;
            r_game_over   <= 1'b0;
            r_winner      <= WIN_NONE;
            r_count       <= '0;
            r_timer_reset <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_white_flag <= 1'b0;
          r_black_flag <= 1'b0;
          r_game_over  <= 1'b0;
          r_winner     <= WIN_NONE;
        end
      endcase
    end
  end

  assign State      = r_state;
  assign WhiteFlag  = r_white_flag;
  assign BlackFlag  = r_black_flag;
  assign GameOver   = r_game_over;
  assign Winner     = r_winner;
  assign MoveCount  = r_count;
  assign IncWhite   = r_inc_white;
  assign IncBlack   = r_inc_black;
  // Timers are held in reset for as long as the controller is.
  assign TimerReset = r_timer_reset | reset;

endmodule

// File: doc/chess_turn_controller.md
CHESS_TURN_CONTROLLER -- requirements
Module: chess_turn_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops per push-button input (legal range 2..4).
REQ-002 SHALL have parameter MOVE_W, default 8, meaning the width of the half-move counter.
REQ-003 SHALL have parameter INC_EN, default 1, meaning Fischer-increment pulses are enabled (1) or forced low (0).
REQ-004 Reset SHALL be port reset, asynchronous, active-high; clock SHALL be port OutClock.
REQ-005 Ports SHALL be exactly as follows:
- OutClock  in  1  clock; all state changes occur on its rising edge.
- reset  in  1  asynchronous reset, active-high.
- StartPause  in  1  raw push-button level; asynchronous.
- WhiteMove  in  1  raw push-button level; asynchronous.
- BlackMove  in  1  raw push-button level; asynchronous.
- WhiteTimeout  in  1  level from the white countdown timer; synchronous to OutClock.
- BlackTimeout  in  1  level from the black countdown timer; synchronous to OutClock.
- WhiteFlag  out  1  run enable for the white timer.
- BlackFlag  out  1  run enable for the black timer.
- TimerReset  out  1  one-cycle pulse that resets both timers.
- IncWhite  out  1  one-cycle increment pulse for the white timer.
- IncBlack  out  1  one-cycle increment pulse for the black timer.
- GameOver  out  1  high while the game has ended.
- Winner  out  2  00 none, 01 white, 10 black; 11 never driven.
- MoveCount  out  MOVE_W  completed half-moves.
- State  out  3  current FSM state encoding.

Function
REQ-006 Each raw button SHALL pass through SYNC_STAGES flops followed by a rising-edge detector, producing a one-cycle internal event.
REQ-007 A button sampled high at edge N SHALL take effect on the state registers at edge N+SYNC_STAGES+1.
REQ-008 A held button SHALL generate exactly one event; the next event requires the synchronized level to fall and rise again.
REQ-009 State encoding SHALL be IDLE=0, WHITE_RUN=1, BLACK_RUN=2, PAUSED=3, GAME_OVER=4; codes 5..7 SHALL recover to IDLE on the next edge.
REQ-010 IDLE transitions:
- StartPause event -> WHITE_RUN.
- Move events and timeouts are ignored.
REQ-011 WHITE_RUN transitions, in priority order:
- WhiteTimeout=1 -> GAME_OVER, Winner=10.
- Else WhiteMove event -> BLACK_RUN; MoveCount+1; IncWhite pulse.
- Else StartPause event -> PAUSED; the saved side is recorded as white.
REQ-012 BLACK_RUN transitions SHALL mirror WHITE_RUN, using BlackTimeout (Winner=01), BlackMove (-> WHITE_RUN, IncBlack pulse) and StartPause (saved side = black).
REQ-013 In a RUN state, the non-running side's move event and timeout SHALL be ignored, including when both sides' events occur in the same cycle.
REQ-014 PAUSED transitions:
- StartPause event -> the saved RUN state.
- Move events and both timeouts are ignored.
REQ-015 GAME_OVER transitions:
- Outputs and state are held.
- StartPause event -> IDLE, with TimerReset high for that one cycle, MoveCount=0 and Winner=00.
REQ-016 Flag and status decoding:
- WhiteFlag=1 iff State=WHITE_RUN.
- BlackFlag=1 iff State=BLACK_RUN.
- GameOver=1 iff State=GAME_OVER.
- At most one flag is ever high.
REQ-017 IncWhite, IncBlack and TimerReset SHALL be registered, high for exactly one cycle, aligned with the state change that caused them.
REQ-018 When INC_EN=0, IncWhite and IncBlack SHALL be constant 0.
REQ-019 MoveCount SHALL saturate at 2^MOVE_W-1 and never wrap.

Reset
REQ-020 While reset=1, outputs SHALL be State=IDLE, both flags=0, GameOver=0, Winner=00, MoveCount=0, IncWhite=0, IncBlack=0, and TimerReset=1 (combinationally follows reset).
REQ-021 Synchronizer and edge-detect flops SHALL reset to 1, so a button held through reset release generates no event.
REQ-022 Reset asserted in any state, including mid-game or PAUSED, SHALL abort immediately; the saved side is cleared to white.

Verification
REQ-023 Basic turn sequence: reset, then StartPause press -> WhiteFlag=1 at edge 3 after sampling. WhiteMove press -> BlackFlag=1, IncWhite single pulse, MoveCount=1.
REQ-024 Pause and resume: in BLACK_RUN, StartPause -> State=3 with both flags 0. StartPause again -> BlackFlag=1, MoveCount unchanged.
REQ-025 Timeout priority: in WHITE_RUN, WhiteTimeout=1 and a WhiteMove event in the same cycle -> State=4, Winner=10, MoveCount unchanged, no IncWhite.
REQ-026 Ignored events: in WHITE_RUN, BlackMove event and BlackTimeout=1 -> no state change. Holding WhiteMove for 10 cycles -> MoveCount increments once.
REQ-027 Saturation and restart: with MOVE_W=2, five alternating moves -> MoveCount=3. Then GAME_OVER followed by StartPause -> TimerReset one-cycle pulse, State=0, MoveCount=0.
